// File: rtl/motor_pwm_drive.sv
// Two-wheel motor drive: gear/steer to ramped duty targets, direction-reversal sequencing,
// and glitch-free 8-bit PWM generation.
module motor_pwm_drive #(
    parameter int unsigned RAMP_DIV  = 100000,
    parameter int unsigned RAMP_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       brake,
    input  logic [2:0] gear_code,
    input  logic [1:0] steer,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic       dir_l,
    output logic       dir_r,
    output logic [7:0] duty_l,
    output logic [7:0] duty_r,
    output logic       ramp_busy
);

    localparam int unsigned TickW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [TickW-1:0] TickMax = TickW'(RAMP_DIV - 1);
    localparam logic [7:0] Step = 8'(RAMP_STEP);

    typedef enum logic [1:0] {StIdle, StRun, StDecel, StDwell} state_e;

    state_e           state_q;
    logic [TickW-1:0] tick_cnt_q;
    logic [7:0]       pwm_cnt_q;
    logic [7:0]       cmp_l_q;
    logic [7:0]       cmp_r_q;

    logic       tick;
    logic       req_dir;
    logic       gear_go;
    logic       dir_ok;
    logic       duties_zero;
    logic       cmps_zero;
    logic [7:0] base;
    logic [7:0] tgt_l;
    logic [7:0] tgt_r;
    logic [7:0] eff_l;
    logic [7:0] eff_r;

    function automatic logic [7:0] ramp(input logic [7:0] cur, input logic [7:0] tgt);
        if (tgt > cur) begin
            return ((tgt - cur) >= Step) ? cur + Step : tgt;
        end else if (cur > tgt) begin
            return ((cur - tgt) >= Step) ? cur - Step : tgt;
        end else begin
            return cur;
        end
    endfunction

    always_comb begin
        case (gear_code)
            3'd1:    base = 8'd51;
            3'd2:    base = 8'd102;
            3'd3:    base = 8'd153;
            3'd4:    base = 8'd204;
            3'd5:    base = 8'd255;
            3'd6:    base = 8'd77;
            default: base = 8'd0;
        endcase
        tgt_l       = (steer == 2'd2) ? (base >> 1) : base;
        tgt_r       = (steer == 2'd1) ? (base >> 1) : base;
        req_dir     = (gear_code != 3'd6);
        gear_go     = (gear_code != 3'd0) && (gear_code != 3'd7);
        dir_ok      = (req_dir == dir_l);
        tick        = (tick_cnt_q == TickMax);
        duties_zero = (duty_l == 8'd0) && (duty_r == 8'd0);
        cmps_zero   = (cmp_l_q == 8'd0) && (cmp_r_q == 8'd0);
        // Outside RUN, or with a pending reversal, the only legal target is standstill.
        if (state_q == StRun && dir_ok) begin
            eff_l = tgt_l;
            eff_r = tgt_r;
        end else begin
            eff_l = 8'd0;
            eff_r = 8'd0;
        end
        ramp_busy = (duty_l != eff_l) || (duty_r != eff_r) ||
                    (state_q == StDecel) || (state_q == StDwell);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            pwm_cnt_q  <= 8'd0;
            cmp_l_q    <= 8'd0;
            cmp_r_q    <= 8'd0;
            duty_l     <= 8'd0;
            duty_r     <= 8'd0;
            dir_l      <= 1'b1;
            dir_r      <= 1'b1;
            pwm_l      <= 1'b0;
            pwm_r      <= 1'b0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TickW'(1);
            pwm_cnt_q  <= pwm_cnt_q + 8'd1;
            if (brake || !en) begin
                state_q <= StIdle;
                duty_l  <= 8'd0;
                duty_r  <= 8'd0;
                cmp_l_q <= 8'd0;
                cmp_r_q <= 8'd0;
                pwm_l   <= 1'b0;
                pwm_r   <= 1'b0;
            end else begin
                // Compare values only change at the period boundary to avoid runt pulses.
                if (pwm_cnt_q == 8'hff) begin
                    cmp_l_q <= duty_l;
                    cmp_r_q <= duty_r;
                end
                pwm_l <= (pwm_cnt_q < cmp_l_q);
                pwm_r <= (pwm_cnt_q < cmp_r_q);
                case (state_q)
                    StIdle: begin
                        duty_l <= 8'd0;
                        duty_r <= 8'd0;
                        if (gear_go) state_q <= StRun;
                    end
                    StRun: begin
                        if (tick) begin
                            duty_l <= ramp(duty_l, eff_l);
                            duty_r <= ramp(duty_r, eff_r);
                        end
                        if (!dir_ok) begin
                            state_q <= (duties_zero && cmps_zero) ? StDwell : StDecel;
                        end else if (duties_zero && !gear_go) begin
                            state_q <= StIdle;
                        end
                    end
                    StDecel: begin
                        if (tick) begin
                            duty_l <= ramp(duty_l, eff_l);
                            duty_r <= ramp(duty_r, eff_r);
                        end
                        // Wait for the compare registers too, so the bridge is fully off.
                        if (duties_zero && cmps_zero) state_q <= StDwell;
                    end
                    StDwell: begin
                        if (tick) begin
                            dir_l   <= req_dir;
                            dir_r   <= req_dir;
                            state_q <= StRun;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
